// File: rtl/switch_led_mmio.sv
// switch_led_mmio
// ---------------------------------------------------------------------------
// Memory-mapped I/O responder for the lab CPU data bus. It owns the board
// LEDs and the raw board switches.
//
// Register map (word offset on addr):
//   0 LED_DATA  R/W   bits[LED_W-1:0], upper bits read 0
//   1 SW_STATE  RO    debounced switch state, zero-extended (writes are acked, ignored)
//   2 SW_CHANGE R/W1C sticky per-switch change flags; a set beats a same-cycle clear
//   3 CTRL      R/W   bit0 led_src, bits[8+SW_W-1:8] irq_mask
//
// Ports:
//   clock    system clock, rising edge
//   reset    asynchronous active-low reset
//   req/we/addr/wdata  bus request; req is held until ack
//   rdata    read data, valid only in the ack cycle, 0 otherwise
//   ack      one-cycle completion pulse, one cycle after req is accepted
//   switches raw asynchronous switches
//   LED      board LEDs (registered)
//   irq      switch-change interrupt
//
// Optional feature: define SWITCH_LED_MMIO_IRQ_EN to drive irq from
// |(SW_CHANGE & irq_mask). Without it irq is held at 0 while irq_mask
// still reads and writes normally.
// ---------------------------------------------------------------------------
module switch_led_mmio #(
    parameter int SW_W            = 3,
    parameter int LED_W           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    input  logic [SW_W-1:0]   switches,
    output logic [LED_W-1:0]  LED,
    output logic              irq
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    // Counter value on which a still-present mismatch is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic                accept_s;

    logic                ack_r;
    logic [31:0]         rdata_r;
    logic [31:0]         rd_word_s;

    logic [LED_W-1:0]    led_data_r;
    logic [LED_W-1:0]    led_r;
    logic [LED_W-1:0]    led_next_s;
    logic                led_src_r;
    logic [SW_W-1:0]     irq_mask_r;
    logic                irq_r;

    logic [SW_W-1:0]     sync1_r;
    logic [SW_W-1:0]     sync2_r;
    logic [SW_W-1:0]     deb_r;
    logic [SW_W-1:0]     toggle_s;
    logic [CNT_W-1:0]    cnt_r      [SW_W];
    logic [CNT_W-1:0]    cnt_next_s [SW_W];

    logic [SW_W-1:0]     chg_r;
    logic [SW_W-1:0]     chg_clr_s;
    logic [SW_W-1:0]     chg_next_s;

    logic                wr_led_s;
    logic                wr_chg_s;
    logic                wr_ctrl_s;
    logic                unused_ok_s;

    // Only low wdata bits land in registers; the rest are intentionally dropped.
    assign unused_ok_s = ^wdata;

    // Handshake state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: a request is accepted only in IDLE; ACK always returns to IDLE,
    // so a req still high afterwards starts a fresh transaction.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_ACK;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Writes commit on the accepting edge, so the request fields are used
    // directly there instead of being held for the ACK cycle.
    assign wr_led_s  = accept_s && we && (addr == 2'd0);
    assign wr_chg_s  = accept_s && we && (addr == 2'd2);
    assign wr_ctrl_s = accept_s && we && (addr == 2'd3);

    // Read mux; unused upper bits stay zero.
    always_comb begin
        rd_word_s = 32'd0;
        case (addr)
            2'd0: rd_word_s = 32'(led_data_r);
            2'd1: rd_word_s = 32'(deb_r);
            2'd2: rd_word_s = 32'(chg_r);
            2'd3: begin
                rd_word_s[0]         = led_src_r;
                rd_word_s[8 +: SW_W] = irq_mask_r;
            end
            default: rd_word_s = 32'd0;
        endcase
    end

    // Bus response: ack and rdata are live for the single ACK cycle only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            ack_r   <= accept_s;
            rdata_r <= (accept_s && !we) ? rd_word_s : 32'd0;
        end
    end

    // Software-visible control registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_data_r <= {LED_W{1'b0}};
            led_src_r  <= 1'b0;
            irq_mask_r <= {SW_W{1'b0}};
        end else begin
            if (wr_led_s) begin
                led_data_r <= wdata[LED_W-1:0];
            end
            if (wr_ctrl_s) begin
                led_src_r  <= wdata[0];
                irq_mask_r <= wdata[8 +: SW_W];
            end
        end
    end

    // Two-flop synchronizer for the asynchronous switches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= {SW_W{1'b0}};
            sync2_r <= {SW_W{1'b0}};
        end else begin
            sync1_r <= switches;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce: count consecutive mismatching cycles, accept on the last.
    // The counter stops at CNT_LAST, so it never wraps.
    always_comb begin
        toggle_s = {SW_W{1'b0}};
        for (int i = 0; i < SW_W; i++) begin
            cnt_next_s[i] = cnt_r[i];
            if (sync2_r[i] != deb_r[i]) begin
                if (cnt_r[i] == CNT_LAST) begin
                    toggle_s[i]   = 1'b1;
                    cnt_next_s[i] = {CNT_W{1'b0}};
                end else begin
                    cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
                end
            end else begin
                cnt_next_s[i] = {CNT_W{1'b0}};
            end
        end
    end

    // W1C clear mask; OR-ing toggles in afterwards makes a same-cycle set win.
    always_comb begin
        chg_clr_s  = wr_chg_s ? wdata[SW_W-1:0] : {SW_W{1'b0}};
        chg_next_s = (chg_r & ~chg_clr_s) | toggle_s;
    end

    // Debounced state, counters and sticky change flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb_r <= {SW_W{1'b0}};
            chg_r <= {SW_W{1'b0}};
            for (int i = 0; i < SW_W; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            deb_r <= deb_r ^ toggle_s;
            chg_r <= chg_next_s;
            for (int i = 0; i < SW_W; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    // LED source select, registered one cycle behind its source.
    always_comb begin
        if (led_src_r) begin
            led_next_s = LED_W'(deb_r);
        end else begin
            led_next_s = led_data_r;
        end
    end

    // LED output register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_r <= {LED_W{1'b0}};
        end else begin
            led_r <= led_next_s;
        end
    end

    // Interrupt register; held low when the interrupt feature is not built.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_r <= 1'b0;
        end else begin
`ifdef SWITCH_LED_MMIO_IRQ_EN
            irq_r <= |(chg_r & irq_mask_r);
`else
            irq_r <= 1'b0;
`endif
        end
    end

    assign ack   = ack_r;
    assign rdata = rdata_r;
    assign LED   = led_r;
    assign irq   = irq_r;

endmodule
